// File: rtl/guitar_pkg.sv
// Shared types and default geometry for the falling-note scheduler.
package guitar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MOVE,
    FETCH,
    READ,
    SPAWN,
    DRAIN
  } state_t;

  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_SLOTS    = 3;
  localparam int unsigned DEF_SCREEN_H = 480;
  localparam int unsigned DEF_NOTE_H   = 50;
  localparam int unsigned DEF_HIT_Y    = 350;
  localparam int unsigned DEF_HIT_H    = 20;

  localparam int unsigned Y_W    = 10;
  localparam int unsigned YX_W   = Y_W + 1;
  localparam int unsigned ADDR_W = 6;

endpackage

// File: rtl/lane_slot_bank.sv
// One lane's note slots: move/retire, spawn into lowest free slot, hit-line overlap.
module lane_slot_bank
  import guitar_pkg::*;
#(
  parameter int unsigned SLOTS    = DEF_SLOTS,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned NOTE_H   = DEF_NOTE_H,
  parameter int unsigned HIT_Y    = DEF_HIT_Y,
  parameter int unsigned HIT_H    = DEF_HIT_H,
  parameter int unsigned SPEED    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  move,
  input  logic                  spawn,
  output logic [SLOTS*Y_W-1:0]  slot_y,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [SLOTS-1:0]      survive,
  output logic                  hit,
  output logic                  dropped
);

  localparam logic [YX_W-1:0] SPEED_X   = YX_W'(SPEED);
  localparam logic [YX_W-1:0] SCREEN_X  = YX_W'(SCREEN_H);
  localparam logic [YX_W-1:0] NOTE_X    = YX_W'(NOTE_H);
  localparam logic [YX_W-1:0] HIT_TOP_X = YX_W'(HIT_Y);
  localparam logic [YX_W-1:0] HIT_END_X = YX_W'(HIT_Y + HIT_H);

  logic [Y_W-1:0]  y_q    [SLOTS];
  logic [YX_W-1:0] y_next [SLOTS];
  logic [SLOTS-1:0] valid_q;
  logic [SLOTS-1:0] free_sel;
  logic             taken;
  logic             hit_d;

  // Sums are 11 bits wide so a note near the bottom cannot wrap past the retire line.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      y_next[i]  = {1'b0, y_q[i]} + SPEED_X;
      survive[i] = valid_q[i] && (y_next[i] < SCREEN_X);
    end
  end

  always_comb begin
    taken    = 1'b0;
    free_sel = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!valid_q[i] && !taken) begin
        free_sel[i] = 1'b1;
        taken       = 1'b1;
      end
    end
  end

  always_comb begin
    hit_d = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (valid_q[i] && (({1'b0, y_q[i]} + NOTE_X) > HIT_TOP_X) &&
          ({1'b0, y_q[i]} < HIT_END_X)) begin
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      hit     <= 1'b0;
      dropped <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      hit     <= hit_d;
      dropped <= spawn && !taken;
      if (move) begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (valid_q[i]) begin
            if (survive[i]) begin
              y_q[i] <= y_next[i][Y_W-1:0];
            end else begin
              valid_q[i] <= 1'b0;
              y_q[i]     <= '0;
            end
          end
        end
      end else if (spawn) begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (free_sel[i]) begin
            valid_q[i] <= 1'b1;
            y_q[i]     <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    slot_y = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      slot_y[i*Y_W +: Y_W] = y_q[i];
    end
  end

  assign slot_valid = valid_q;

endmodule

// File: rtl/note_scheduler.sv
// Chart-driven note scheduler: advances falling notes each frame and spawns chart entries on the beat.
module note_scheduler
  import guitar_pkg::*;
#(
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned SLOTS       = DEF_SLOTS,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
  parameter int unsigned NOTE_H      = DEF_NOTE_H,
  parameter int unsigned HIT_Y       = DEF_HIT_Y,
  parameter int unsigned HIT_H       = DEF_HIT_H,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned BEAT_FRAMES = 30,
  parameter int unsigned CHART_LEN   = 63
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         start,
  output logic [ADDR_W-1:0]            chart_addr,
  input  logic [LANES-1:0]             chart_data,
  output logic [LANES*SLOTS*Y_W-1:0]   slot_y,
  output logic [LANES*SLOTS-1:0]       slot_valid,
  output logic [LANES-1:0]             in_hit_window,
  output logic [LANES-1:0]             dropped,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned       BEAT_W    = 16;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_FRAMES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHART_LEN - 1);

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_cnt;
  logic                     pending;
  logic                     exhausted;
  logic [LANES-1:0]         mask_q;
  logic [LANES-1:0]         spawn_lane;
  logic [LANES*SLOTS-1:0]   survive;
  logic                     any_left;
  logic                     tick_now;
  logic                     move;

  assign tick_now = frame_tick | pending;
  assign any_left = |survive;
  assign move     = (state_q == MOVE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    spawn_lane = '0;
    if (state_q == SPAWN) begin
      spawn_lane = mask_q;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_slot_bank #(
      .SLOTS    (SLOTS),
      .SCREEN_H (SCREEN_H),
      .NOTE_H   (NOTE_H),
      .HIT_Y    (HIT_Y),
      .HIT_H    (HIT_H),
      .SPEED    (SPEED)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .move       (move),
      .spawn      (spawn_lane[l]),
      .slot_y     (slot_y[l*SLOTS*Y_W +: SLOTS*Y_W]),
      .slot_valid (slot_valid[l*SLOTS +: SLOTS]),
      .survive    (survive[l*SLOTS +: SLOTS]),
      .hit        (in_hit_window[l]),
      .dropped    (dropped[l])
    );
  end

  // The end-of-playback test uses the post-move occupancy so done lines up with the final retire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = WAIT;
      WAIT:  if (tick_now) state_d = MOVE;
      DRAIN: if (tick_now) state_d = MOVE;
      MOVE: begin
        if (exhausted) begin
          state_d = any_left ? DRAIN : IDLE;
        end else if (beat_cnt == BEAT_LAST) begin
          state_d = FETCH;
        end else begin
          state_d = WAIT;
        end
      end
      FETCH: state_d = READ;
      READ:  state_d = SPAWN;
      SPAWN: state_d = (chart_addr == ADDR_LAST) ? DRAIN : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt   <= '0;
      pending    <= 1'b0;
      exhausted  <= 1'b0;
      mask_q     <= '0;
      chart_addr <= '0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= move && exhausted && !any_left;

      if ((state_q == WAIT) || (state_q == DRAIN)) begin
        pending <= 1'b0;
      end else if (frame_tick) begin
        pending <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            chart_addr <= '0;
            beat_cnt   <= '0;
            exhausted  <= 1'b0;
          end
        end
        MOVE: begin
          if (!exhausted && (beat_cnt == BEAT_LAST)) begin
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        READ: mask_q <= chart_data;
        SPAWN: begin
          chart_addr <= chart_addr + 1'b1;
          if (chart_addr == ADDR_LAST) begin
            exhausted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Frame-level reference model feeding a scoreboard for note_scheduler.
module tb_note_scheduler;

  localparam int CLEN = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_tick;
  logic         start;
  logic [5:0]   chart_addr;
  logic [3:0]   chart_data;
  logic [119:0] slot_y;
  logic [11:0]  slot_valid;
  logic [3:0]   in_hit_window;
  logic [3:0]   dropped;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  note_scheduler #(.CHART_LEN(CLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .chart_addr    (chart_addr),
    .chart_data    (chart_data),
    .slot_y        (slot_y),
    .slot_valid    (slot_valid),
    .in_hit_window (in_hit_window),
    .dropped       (dropped),
    .busy          (busy),
    .done          (done)
  );

  logic [3:0] rom [64];
  always @(posedge clk) chart_data <= rom[chart_addr];

  int drop_cnt [4] = '{default: 0};
  int done_cnt = 0;
  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) if (dropped[l]) drop_cnt[l]++;
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0]  valid;
    logic [119:0] y;
    logic [3:0]   hit;
    logic [3:0]   drop;
    logic [5:0]   addr;
    logic         done;
  } exp_t;

  exp_t sb [$];
  exp_t cur;

  int m_y [4][3];
  bit m_v [4][3];
  int m_beat, m_addr;
  bit m_exh, m_run;

  function void model_reset();
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 3; s++) begin
        m_y[l][s] = 0;
        m_v[l][s] = 0;
      end
    m_beat = 0;
    m_addr = 0;
    m_exh  = 0;
    m_run  = 1;
  endfunction

  function void model_frame();
    logic [3:0] ent;
    bit any, placed;
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 3; s++)
        if (m_v[l][s]) begin
          m_y[l][s] = m_y[l][s] + 1;
          if (m_y[l][s] >= 480) begin
            m_v[l][s] = 0;
            m_y[l][s] = 0;
          end
        end
    if (m_exh) begin
      any = 0;
      for (int l = 0; l < 4; l++)
        for (int s = 0; s < 3; s++) any |= m_v[l][s];
      if (!any) begin
        cur.done = 1'b1;
        m_run = 0;
      end
    end else if (m_beat == 29) begin
      m_beat = 0;
      ent = rom[m_addr];
      for (int l = 0; l < 4; l++) begin
        if (ent[l]) begin
          placed = 0;
          for (int s = 0; s < 3; s++)
            if (!placed && !m_v[l][s]) begin
              m_v[l][s] = 1;
              m_y[l][s] = 0;
              placed = 1;
            end
          if (!placed) cur.drop[l] = 1'b1;
        end
      end
      if (m_addr == CLEN - 1) m_exh = 1;
      m_addr++;
    end else begin
      m_beat++;
    end
    for (int l = 0; l < 4; l++) begin
      cur.hit[l] = 1'b0;
      for (int s = 0; s < 3; s++) begin
        cur.valid[l*3+s] = m_v[l][s];
        cur.y[(l*3+s)*10 +: 10] = 10'(m_y[l][s]);
        if (m_v[l][s] && (m_y[l][s] + 50 > 350) && (m_y[l][s] < 370)) cur.hit[l] = 1'b1;
      end
    end
    cur.addr = 6'(m_addr);
  endfunction

  // extra: a second tick lands while the first one is still being processed
  task automatic do_frame(input bit extra);
    exp_t e;
    int base [4];
    int dbase;
    logic [31:0] dobs, dexp;
    for (int l = 0; l < 4; l++) base[l] = drop_cnt[l];
    dbase = done_cnt;
    cur.drop = '0;
    cur.done = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    model_frame();
    if (extra) begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      model_frame();
    end
    sb.push_back(cur);
    repeat (8) @(negedge clk);
    e = sb.pop_front();
    for (int l = 0; l < 4; l++) begin
      dobs[l*8 +: 8] = 8'(drop_cnt[l] - base[l]);
      dexp[l*8 +: 8] = {7'd0, e.drop[l]};
    end
    check_eq("slot_valid", slot_valid, e.valid);
    check_eq("slot_y", slot_y, e.y);
    check_eq("hit_window", in_hit_window, e.hit);
    check_eq("dropped", dobs, dexp);
    check_eq("chart_addr", chart_addr, e.addr);
    check_eq("done_pulse", 32'(done_cnt - dbase), {31'd0, e.done});
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 4'b0000;
    rom[0] = 4'b0101;
    rom[1] = 4'b0100;
    rom[2] = 4'b0100;
    rom[3] = 4'b0100;
    rom[4] = 4'b1111;
    rom[5] = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", slot_valid, 12'h000);
    check_eq("rst_y", slot_y, 120'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_addr", chart_addr, 6'd0);
    check_eq("rst_hit", in_hit_window, 4'h0);
    check_eq("rst_done", done, 1'b0);
    reset = 1'b0;

    model_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("busy_run", busy, 1'b1);
    for (int f = 0; f < 1000 && m_run; f++) begin
      if (f == 100) begin
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
      do_frame(f == 59);
    end
    check_eq("model_finished", m_run, 1'b0);
    check_eq("busy_end", busy, 1'b0);
    check_eq("done_total", done_cnt, 1);

    // Second playback: reset lands in the SPAWN cycle of the first all-lane entry.
    rom[0] = 4'b1111;
    model_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int f = 0; f < 29; f++) do_frame(1'b0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    frame_tick = 1'b0;
    check_eq("rst2_valid", slot_valid, 12'h000);
    check_eq("rst2_y", slot_y, 120'd0);
    check_eq("rst2_busy", busy, 1'b0);
    check_eq("rst2_addr", chart_addr, 6'd0);
    check_eq("rst2_drop", dropped, 4'h0);
    repeat (4) @(negedge clk);
    check_eq("rst2_hold_valid", slot_valid, 12'h000);
    check_eq("rst2_hold_busy", busy, 1'b0);
    check_eq("rst2_hit", in_hit_window, 4'h0);
    check_eq("done_total2", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, number of note lanes.
REQ-002 SHALL have parameter SLOTS, default 3, note slots per lane.
REQ-003 SHALL have parameter SCREEN_H, default 480, retire threshold in pixels.
REQ-004 SHALL have parameter NOTE_H, default 50, note height in pixels.
REQ-005 SHALL have parameter HIT_Y / HIT_H, defaults 350 / 20, hit-line top and height.
REQ-006 SHALL have parameter SPEED, default 1, pixels moved per frame.
REQ-007 SHALL have parameter BEAT_FRAMES, default 30, frames between chart entries.
REQ-008 SHALL have parameter CHART_LEN, default 63, number of chart entries.
REQ-009 SHALL have ports, one per line:
 clk  in  1  100 MHz system clock, all logic on rising edge.
 reset  in  1  synchronous, active-high.
 frame_tick  in  1  one-cycle pulse per video frame (screenEnd, synchronised to clk).
 start  in  1  one-cycle pulse, begins chart playback.
 chart_addr  out  6  chart ROM address.
 chart_data  in  LANES  lane mask; valid one cycle after chart_addr.
 slot_y  out  LANES*SLOTS*10  top-edge y per slot, lane-major, slot-minor.
 slot_valid  out  LANES*SLOTS  slot occupied.
 in_hit_window  out  LANES  lane has a note overlapping the hit line.
 dropped  out  LANES  one-cycle pulse: spawn requested, no free slot.
 busy  out  1  high outside IDLE.
 done  out  1  one-cycle pulse at end of playback.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, MOVE, FETCH, READ, SPAWN, DRAIN.
REQ-011 IDLE -> WAIT on start; start outside IDLE SHALL be ignored.
REQ-012 WAIT -> MOVE on frame_tick or pending tick; DRAIN -> MOVE likewise.
REQ-013 MOVE (1 cycle): every valid slot y <= y+SPEED; slot with new y >= SCREEN_H SHALL clear valid, y <= 0.
REQ-014 After MOVE: beat_cnt == BEAT_FRAMES-1 and chart not exhausted -> FETCH, beat_cnt <= 0; otherwise beat_cnt++, return to WAIT (or DRAIN).
REQ-015 FETCH drives chart_addr; READ samples chart_data one cycle later; SPAWN acts on the sampled mask.
REQ-016 SPAWN: per set mask bit, the lowest-index invalid slot of that lane SHALL become valid with y=0; lanes processed in parallel in one cycle.
REQ-017 SPAWN with no free slot in a lane SHALL pulse that lane's dropped bit for one cycle, other lanes unaffected.
REQ-018 After SPAWN, chart_addr increments; if the spawned entry was index CHART_LEN-1 -> DRAIN, else WAIT.
REQ-019 DRAIN: no spawns; when all slot_valid are 0 after a MOVE, done pulses one cycle and FSM -> IDLE.
REQ-020 frame_tick arriving outside WAIT/DRAIN SHALL set a single pending flag, cleared when serviced; a second tick while pending is lost.
REQ-021 in_hit_window[l] SHALL be registered, 1-cycle latency from slot state: any valid slot with y+NOTE_H > HIT_Y and y < HIT_Y+HIT_H.
REQ-022 y arithmetic SHALL be 10-bit unsigned; sum computed 11-bit before retire compare, no wrap.
REQ-023 busy SHALL be combinational: state != IDLE.

Reset
REQ-024 reset SHALL force IDLE; slot_valid, slot_y, chart_addr, beat_cnt, pending, dropped, done, in_hit_window all 0.
REQ-025 reset mid-playback SHALL take priority over frame_tick, start and every FSM action in that cycle.

Structure
REQ-026 Shared package guitar_pkg SHALL hold the state enumeration and default constants (LANES, SLOTS, SCREEN_H, NOTE_H, HIT_Y, HIT_H).
REQ-027 One sub-module lane_slot_bank SHALL hold one lane's SLOTS registers with move, spawn, retire, free-slot select, hit-window logic; instantiated LANES times.

Verification
REQ-028 Start, chart[0]=4'b0001, 30 ticks -> FETCH at addr 0; lane0 slot0 valid, y=0; after 350 more ticks in_hit_window[0]=1 (y=350 window 301..369).
REQ-029 Note at y=479, one tick -> slot_valid cleared, y=0, other slots unchanged.
REQ-030 Lane 2 all 3 slots valid, chart entry 4'b0100 -> dropped=4'b0100 one cycle; slots unchanged.
REQ-031 CHART_LEN=2, masks 4'b1111 then 0 -> after last note retires, done pulses once, busy falls.
REQ-032 frame_tick asserted during SPAWN -> serviced by next MOVE; all notes advance exactly once per tick.
REQ-033 reset asserted in SPAWN with mask 4'b1111 -> no slot valid next cycle, state IDLE, outputs 0.
